// File: rtl/unidade_controle.sv
// unidade_controle: sequencer for the 4-bit accumulate datapath.
// It runs one job per accepted start: load A, load B, then N ALU feedback
// writes into A, then a one-cycle done pulse.
// Optional build macro UC_PAUSE_EN adds a 'pause' input that freezes EXEC.
// Outputs are decoded from registered state only. The one exception is
// 'pause', which, when enabled, gates wrA in the same cycle.
module unidade_controle #(
    parameter int         ITER_W  = 4,
    parameter logic [1:0] IDLE_OP = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ITER_W-1:0] iter,
`ifdef UC_PAUSE_EN
    input  logic              pause,
`endif
    output logic              selA,
    output logic              wrA,
    output logic              wrB,
    output logic [1:0]        aluOp,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

    state_t            state_reg, state_next;
    logic [1:0]        op_reg, op_next;
    logic [ITER_W-1:0] cnt_reg, cnt_next;
    logic              pause_act;

    // pause only exists in the pausable build; otherwise EXEC never stalls.
`ifdef UC_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // State, captured job operation and remaining-iteration counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            op_reg    <= 2'b00;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic and the Moore output decode.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        cnt_next   = cnt_reg;
        selA       = 1'b0;
        wrA        = 1'b0;
        wrB        = 1'b0;
        aluOp      = op_reg;
        busy       = 1'b1;
        done       = 1'b0;

        case (state_reg)
            IDLE: begin
                aluOp = IDLE_OP;
                busy  = 1'b0;
                // Job parameters are latched here only. The rest of the job
                // ignores the op and iter inputs.
                if (start) begin
                    state_next = LOAD_A;
                    op_next    = op;
                    cnt_next   = iter;
                end
            end
            LOAD_A: begin
                selA       = 1'b1;
                wrA        = 1'b1;
                state_next = LOAD_B;
            end
            LOAD_B: begin
                wrB = 1'b1;
                // A zero-iteration job skips EXEC entirely.
                if (cnt_reg != '0) state_next = EXEC;
                else               state_next = DONE;
            end
            EXEC: begin
                wrA = !pause_act;
                // Leaving on cnt == 1 means the counter never wraps below zero.
                if (!pause_act) begin
                    cnt_next = cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                // Unused encodings drop back to IDLE with idle outputs.
                aluOp      = IDLE_OP;
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule
